// File: rtl/int_to_float_ctrl.sv
// Two-requester, round-robin, multi-cycle integer-to-IEEE-754 single converter.
// Optional two's-complement operands: define INT_TO_FLOAT_SIGNED_EN.
module int_to_float_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [31:0]      b
);

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

  localparam logic [7:0] EXP_TOP = 8'(127 + WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] val;
  logic [4:0]       s;
  logic             neg;
  logic             id;
  logic             last;

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] mag;
  logic             sign_in;
  logic             norm_stop;
  logic [7:0]       exp_f;
  logic [22:0]      mant;
  logic [31:0]      packed_f;

  assign busy      = (state != IDLE);
  assign norm_stop = (val == '0) || val[WIDTH-1];
  assign sel       = gnt1 ? a1 : a0;

`ifdef INT_TO_FLOAT_SIGNED_EN
  // Negating as unsigned WIDTH bits keeps the most-negative value exact.
  assign sign_in = sel[WIDTH-1];
  assign mag     = sign_in ? -sel : sel;
`else
  assign sign_in = 1'b0;
  assign mag     = sel;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rst_n) begin
          if (req0 && (!req1 || last)) gnt0 = 1'b1;
          else if (req1)               gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) state_nxt = NORM;
      end
      NORM:    if (norm_stop) state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exp_f                = EXP_TOP - {3'b000, s};
    mant                 = '0;
    mant[22 -: WIDTH-1]  = val[WIDTH-2:0];
    packed_f             = (val == '0) ? 32'h0000_0000 : {neg, exp_f, mant};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      val     <= '0;
      s       <= '0;
      neg     <= 1'b0;
      id      <= 1'b0;
      last    <= 1'b1;
      done    <= 1'b0;
      done_id <= 1'b0;
      b       <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == PACK);
      if (gnt0 || gnt1) begin
        val  <= mag;
        s    <= '0;
        neg  <= sign_in;
        id   <= gnt1;
        last <= gnt1;
      end
      if (state == NORM && !norm_stop) begin
        val <= val << 1;
        s   <= s + 5'd1;
      end
      if (state == PACK) begin
        b       <= packed_f;
        done_id <= id;
      end
    end
  end

endmodule

// File: tb/tb_int_to_float_ctrl.sv
// Directed self-checking bench for int_to_float_ctrl (WIDTH=8); inputs change
// 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_int_to_float_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [7:0]  a0, a1;
  logic        gnt0, gnt1, busy, done, done_id;
  logic [31:0] b;

  int tests = 0;
  int fails = 0;

  int_to_float_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .req1(req1), .a1(a1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .done(done), .done_id(done_id), .b(b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single job on requester 0; called 1 unit after a rising edge in IDLE.
  task automatic job0(input logic [7:0] a, input logic [31:0] exp_b, input int exp_cyc);
    int n;
    req0 = 1'b1;
    a0   = a;
    @(negedge clk);
    check($sformatf("gnt0 a=%h", a), {31'b0, gnt0}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check($sformatf("busy a=%h", a), {31'b0, busy}, 32'd1);
    for (n = 1; n < 40 && !done; n++) @(negedge clk);
    check($sformatf("done_cycle a=%h", a), n, exp_cyc);
    check($sformatf("b a=%h", a), b, exp_b);
    check($sformatf("done_id a=%h", a), {31'b0, done_id}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit early;
    int ng, nd;
    int gid[4], gcyc[4], did[4], dcyc[4];
    logic [31:0] db[4];

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; a0 = '0; a1 = '0;
    #1;
    check("reset_b", b, 32'h0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Sweep on requester 0.
    job0(8'd0, 32'h0000_0000, 3);
    job0(8'd1, 32'h3F80_0000, 10);
    job0(8'd2, 32'h4000_0000, 9);
    job0(8'd3, 32'h4040_0000, 9);
    job0(8'd4, 32'h4080_0000, 8);
`ifdef INT_TO_FLOAT_SIGNED_EN
    job0(8'hFF, 32'hBF80_0000, 10);
    job0(8'h80, 32'hC300_0000, 3);
    job0(8'd127, 32'h42FE_0000, 4);
`else
    job0(8'd255, 32'h437F_0000, 3);
    job0(8'h80, 32'h4300_0000, 3);
`endif

    // Reset in the middle of NORM, with both requests high during reset.
    req0 = 1'b1; a0 = 8'd1;
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_norm_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    #1;
    check("rst_b", b, 32'h0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_gnts", {30'b0, gnt1, gnt0}, 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Post-reset job on requester 0; requester 1 arrives while busy.
    req0 = 1'b1; a0 = 8'd3;
    @(negedge clk);
    check("post_rst_gnt0", {31'b0, gnt0}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b1; a1 = 8'd4;
    early = 1'b0;
    @(negedge clk);
    for (n = 1; n < 40 && !done; n++) begin
      if (gnt1) early = 1'b1;
      @(negedge clk);
    end
    check("gnt1_not_early", {31'b0, early}, 32'd0);
    check("post_rst_cycle", n, 9);
    check("post_rst_b", b, 32'h4040_0000);
    check("gnt1_with_done", {31'b0, gnt1}, 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    for (n = 1; n < 40 && !done; n++) @(negedge clk);
    check("req1_cycle", n, 8);
    check("req1_b", b, 32'h4080_0000);
    check("req1_done_id", {31'b0, done_id}, 32'd1);
    @(posedge clk); #1;

    // Contention: both held for four jobs.
    req0 = 1'b1; a0 = 8'd1; req1 = 1'b1; a1 = 8'd2;
    ng = 0; nd = 0;
    for (int cyc = 0; cyc < 100 && nd < 4; cyc++) begin
      @(negedge clk);
      if (gnt0 && gnt1) check("gnt_onehot", {30'b0, gnt1, gnt0}, 32'd1);
      if (ng < 4 && (gnt0 || gnt1)) begin
        gid[ng] = int'(gnt1); gcyc[ng] = cyc; ng++;
      end
      if (done) begin
        did[nd] = int'(done_id); dcyc[nd] = cyc; db[nd] = b; nd++;
      end
      @(posedge clk); #1;
      if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
    end
    check("rr_grants", ng, 4);
    check("rr_dones", nd, 4);
    for (int i = 0; i < 4 && i < ng && i < nd; i++) begin
      check($sformatf("rr_gid%0d", i), gid[i], i % 2);
      check($sformatf("rr_did%0d", i), did[i], i % 2);
      check($sformatf("rr_b%0d", i), db[i], (i % 2) ? 32'h4000_0000 : 32'h3F80_0000);
      check($sformatf("rr_lat%0d", i), dcyc[i] - gcyc[i], (i % 2) ? 9 : 10);
      if (i < 3) check($sformatf("rr_gap%0d", i), gcyc[i+1], dcyc[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_to_float_ctrl.md
INT_TO_FLOAT_CTRL -- requirements
Module: int_to_float_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, integer operand width; legal range 2..24, so every conversion is exact and needs no rounding.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0  input  1  requester 0 conversion request; held high until gnt0 is seen.
REQ-005 a0  input  WIDTH  requester 0 operand; held stable while req0 is high.
REQ-006 req1  input  1  requester 1 conversion request; same rules as req0.
REQ-007 a1  input  WIDTH  requester 1 operand; held stable while req1 is high.
REQ-008 gnt0  output  1  combinational one-cycle accept for requester 0.
REQ-009 gnt1  output  1  combinational one-cycle accept for requester 1.
REQ-010 busy  output  1  high while a conversion is in flight, i.e. in state NORM or PACK.
REQ-011 done  output  1  registered one-cycle pulse: b is valid.
REQ-012 done_id  output  1  registered; the requester that owns the current b.
REQ-013 b  output  32  registered IEEE-754 single-precision result; holds its value until the next done.

Function
REQ-014 The FSM SHALL have three states:
- IDLE -> NORM on a grant.
- NORM -> PACK when the working value is zero or its bit WIDTH-1 is set; otherwise NORM shifts the value left by 1 and increments the shift count s.
- PACK -> IDLE unconditionally.
REQ-015 In IDLE only, gnt SHALL be asserted to one requester, chosen round-robin:
- if only one requester has req high, that requester is granted;
- if both have req high, the requester not granted last time is granted.
REQ-016 The operand, the requester id and s=0 SHALL be captured at the clock edge that ends the grant cycle.
REQ-017 Timing: if the grant is in cycle 0, done SHALL be high in cycle s+3 only (s = number of shifts); s=0 for a zero operand.
- WIDTH=8, operand 1: done in cycle 10.
- Operand 0 or operand with MSB set: done in cycle 3.
REQ-018 Packing: sign 0; exponent = 127+WIDTH-1-s; mantissa = working value bits [WIDTH-2:0], left-aligned in 23 bits with zero fill below.
REQ-019 A zero operand SHALL produce b=32'h00000000.
REQ-020 Back-to-back: a new grant SHALL be allowed in the same cycle that done is high, giving zero idle cycles between jobs.
REQ-021 Requests SHALL be ignored while busy.
REQ-022 A req dropped before its grant SHALL be discarded with no side effects.
REQ-023 done and done_id SHALL be updated only in the PACK-to-IDLE transition.

Reset
REQ-024 When rst_n=0, the block SHALL immediately reset all of the following, including in the middle of a conversion:
- state = IDLE;
- b = 0, done = 0, done_id = 0, busy = 0;
- last-granted = 1, so requester 0 wins the first contention;
- the in-flight job is discarded.
REQ-025 gnt0 and gnt1 SHALL be 0 while rst_n=0.

Configuration
REQ-026 With INT_TO_FLOAT_SIGNED_EN defined, operands SHALL be treated as two's complement:
- sign = operand bit WIDTH-1;
- the magnitude is the negated operand, interpreted as unsigned WIDTH bits, so the most-negative value converts exactly;
- the sign is carried to b[31].
REQ-027 With INT_TO_FLOAT_SIGNED_EN undefined, operands SHALL be unsigned and b[31] SHALL always be 0.

Verification (WIDTH=8)
REQ-028 Reset mid-NORM -> b=0, done=0, busy=0 immediately; the next request converts correctly.
REQ-029 Unsigned single-requester sweep on requester 0 -> expected results and done cycle:

| a0  | b            | done cycle |
|-----|--------------|------------|
| 1   | 32'h3F800000 | 10         |
| 2   | 32'h40000000 | 9          |
| 3   | 32'h40400000 | 9          |
| 4   | 32'h40800000 | 8          |
| 255 | 32'h437F0000 | 3          |
| 0   | 32'h00000000 | 3          |

REQ-030 req0 and req1 held high together for 4 jobs (a0=1, a1=2) -> grants alternate 0,1,0,1; done_id sequence 0,1,0,1; no idle cycles between jobs.
REQ-031 req1 asserted while busy and held high -> gnt1 is asserted in the cycle done is high, not before.
REQ-032 INT_TO_FLOAT_SIGNED_EN defined -> results:

| operand | b            |
|---------|--------------|
| -1      | 32'hBF800000 |
| -128    | 32'hC3000000 |
| 127     | 32'h42FE0000 |

REQ-033 INT_TO_FLOAT_SIGNED_EN undefined, operand 8'h80 -> b=32'h43000000.
